// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache, 8 lines x 4 bytes.
// Define DCACHE_STATS_EN to build the saturating hit/miss counters.
module dcache_ctrl (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSYWAIT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT,
  output logic [15:0] HIT_COUNT,
  output logic [15:0] MISS_COUNT
);

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FETCH,
    UPDATE
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [7:0]  valid;
  logic [7:0]  dirty;
  logic [2:0]  tags [8];
  logic [31:0] data [8];
  logic [31:0] hold;
  logic        first;

  logic [2:0] tg;
  logic [2:0] idx;
  logic [1:0] off;
  logic       req;
  logic       hit;
  logic       wr_hit;
  logic       mem_done;

  assign tg       = ADDRESS[7:5];
  assign idx      = ADDRESS[4:2];
  assign off      = ADDRESS[1:0];
  assign req      = READ | WRITE;
  assign hit      = valid[idx] && (tags[idx] == tg);
  assign wr_hit   = (state == IDLE) && WRITE && hit;
  // The memory's busy flag is stale during the first cycle of a request.
  assign mem_done = ~first & ~MEM_BUSYWAIT;

  assign READDATA = (RESET && state == IDLE && READ && !WRITE && hit)
                  ? data[idx][{off, 3'b000} +: 8] : 8'h00;

  always_comb begin
    state_nx      = state;
    BUSYWAIT      = 1'b0;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = 6'h00;
    MEM_WRITEDATA = 32'h0;
    unique case (state)
      IDLE: begin
        if (req && !hit) begin
          BUSYWAIT = 1'b1;
          state_nx = (valid[idx] && dirty[idx]) ? WRITEBACK : FETCH;
        end
      end
      WRITEBACK: begin
        BUSYWAIT      = 1'b1;
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {tags[idx], idx};
        MEM_WRITEDATA = data[idx];
        if (mem_done) state_nx = FETCH;
      end
      FETCH: begin
        BUSYWAIT    = 1'b1;
        MEM_READ    = 1'b1;
        MEM_ADDRESS = {tg, idx};
        if (mem_done) state_nx = UPDATE;
      end
      UPDATE: begin
        BUSYWAIT = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // Request lines must fall the instant reset asserts, even with a request held.
    if (!RESET) begin
      BUSYWAIT      = 1'b0;
      MEM_READ      = 1'b0;
      MEM_WRITE     = 1'b0;
      MEM_ADDRESS   = 6'h00;
      MEM_WRITEDATA = 32'h0;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
      first <= 1'b0;
      valid <= '0;
      dirty <= '0;
    end else begin
      state <= state_nx;
      first <= (state_nx != state);
      if (state == UPDATE) begin
        valid[idx] <= 1'b1;
        dirty[idx] <= 1'b0;
      end else if (wr_hit) begin
        dirty[idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (state == FETCH && mem_done) hold <= MEM_READDATA;
    if (state == UPDATE) begin
      data[idx] <= hold;
      tags[idx] <= tg;
    end else if (wr_hit) begin
      data[idx][{off, 3'b000} +: 8] <= WRITEDATA;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
  logic        post_fill;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      post_fill <= 1'b0;
    end else begin
      post_fill <= (state == UPDATE);
      if (state == IDLE && req && hit && !post_fill && hit_cnt != 16'hFFFF)
        hit_cnt <= hit_cnt + 16'd1;
      if (state == IDLE && state_nx != IDLE && miss_cnt != 16'hFFFF)
        miss_cnt <= miss_cnt + 16'd1;
    end
  end

  assign HIT_COUNT  = hit_cnt;
  assign MISS_COUNT = miss_cnt;
`else
  assign HIT_COUNT  = 16'h0000;
  assign MISS_COUNT = 16'h0000;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: directed scenarios, then random accesses
// checked against an array-based cache model and a latency memory.
module tb_dcache_ctrl;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        READ = 1'b0;
  logic        WRITE = 1'b0;
  logic [7:0]  ADDRESS = 8'h00;
  logic [7:0]  WRITEDATA = 8'h00;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;
  logic [15:0] HIT_COUNT;
  logic [15:0] MISS_COUNT;

  int total = 0;
  int bad = 0;

  dcache_ctrl dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE),
    .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA),
    .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA),
    .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT),
    .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] seed(int a);
    if (a == 9) return 32'hDDCCBBAA;
    return 32'(a) * 32'h9E3779B1 ^ 32'h5A5AC3C3;
  endfunction

  // Memory: busy for lat cycles of a request, then serves/accepts the block.
  logic [31:0] mem [64];
  bit   [63:0] wrt;
  int          mcnt;
  int          lat = 1;

  assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (mcnt < lat);
  assign MEM_READDATA = MEM_BUSYWAIT ? 32'hDEADBEEF
                      : (wrt[MEM_ADDRESS] ? mem[MEM_ADDRESS] : seed(int'(MEM_ADDRESS)));

  always @(posedge CLK) begin
    if (MEM_READ || MEM_WRITE) begin
      if (!MEM_BUSYWAIT) begin
        if (MEM_WRITE) begin
          mem[MEM_ADDRESS] <= MEM_WRITEDATA;
          wrt[MEM_ADDRESS] <= 1'b1;
        end
        mcnt <= 0;
      end else begin
        mcnt <= mcnt + 1;
      end
    end else begin
      mcnt <= 0;
    end
  end

  // Reference cache model
  bit          mvalid [8];
  bit          mdirty [8];
  logic [2:0]  mtag [8];
  logic [31:0] mline [8];
  logic [31:0] rmem [64];
  int          hits;
  int          misses;

  bit          e_hit;
  bit          e_wb;
  logic [5:0]  e_wbaddr;
  logic [31:0] e_wbdata;
  logic [5:0]  e_faddr;
  logic [7:0]  e_rdata;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      mvalid[i] = 0;
      mdirty[i] = 0;
    end
    hits = 0;
    misses = 0;
  endtask

  task automatic model(input bit w, input logic [7:0] a, input logic [7:0] d);
    int ix = int'(a[4:2]);
    int of = int'(a[1:0]);
    e_hit = mvalid[ix] && mtag[ix] == a[7:5];
    e_wb = 0;
    e_wbaddr = 6'h00;
    e_wbdata = 32'h0;
    e_faddr = {a[7:5], a[4:2]};
    if (e_hit) begin
      hits++;
    end else begin
      misses++;
      if (mvalid[ix] && mdirty[ix]) begin
        e_wb = 1;
        e_wbaddr = {mtag[ix], a[4:2]};
        e_wbdata = mline[ix];
        rmem[e_wbaddr] = mline[ix];
      end
      mline[ix] = rmem[e_faddr];
      mtag[ix] = a[7:5];
      mvalid[ix] = 1;
      mdirty[ix] = 0;
    end
    if (w) begin
      mline[ix][8*of +: 8] = d;
      mdirty[ix] = 1;
      e_rdata = 8'h00;
    end else begin
      e_rdata = mline[ix][8*of +: 8];
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string nm);
    int eh;
    int em;
`ifdef DCACHE_STATS_EN
    eh = hits;
    em = misses;
`else
    eh = 0;
    em = 0;
`endif
    chk({nm, " hit_count"}, 32'(HIT_COUNT), 32'(eh));
    chk({nm, " miss_count"}, 32'(MISS_COUNT), 32'(em));
  endtask

  // Called at a negedge; returns at a negedge with the request removed.
  task automatic do_acc(input bit r, input bit w, input logic [7:0] a,
                        input logic [7:0] d, input int l, input string nm);
    int n;
    int ex;
    bit swr;
    bit srd;
    bit both;
    logic [5:0] wa;
    logic [5:0] ra;
    logic [31:0] wd;
    lat = l;
    model(w, a, d);
    ex = e_hit ? 0 : (e_wb ? 2 * l + 4 : l + 3);
    READ = r;
    WRITE = w;
    ADDRESS = a;
    WRITEDATA = d;
    n = 0;
    swr = 0;
    srd = 0;
    both = 0;
    wa = 0;
    ra = 0;
    wd = 0;
    forever begin
      #1;
      if (!BUSYWAIT || n > 60) break;
      if (MEM_READ && MEM_WRITE) both = 1;
      if (MEM_WRITE && !swr) begin
        swr = 1;
        wa = MEM_ADDRESS;
        wd = MEM_WRITEDATA;
      end
      if (MEM_READ && !srd) begin
        srd = 1;
        ra = MEM_ADDRESS;
      end
      n++;
      @(negedge CLK);
    end
    chk({nm, " stall"}, 32'(n), 32'(ex));
    chk({nm, " readdata"}, 32'(READDATA), 32'(e_rdata));
    chk({nm, " idle_memreq"}, 32'({MEM_READ, MEM_WRITE}), 32'h0);
    chk({nm, " rd_wr_both"}, 32'(both), 32'h0);
    chk({nm, " wb_seen"}, 32'(swr), 32'(e_wb));
    chk({nm, " fetch_seen"}, 32'(srd), 32'(!e_hit));
    if (e_wb) begin
      chk({nm, " wb_addr"}, 32'(wa), 32'(e_wbaddr));
      chk({nm, " wb_data"}, wd, e_wbdata);
    end
    if (!e_hit) chk({nm, " fetch_addr"}, 32'(ra), 32'(e_faddr));
    @(posedge CLK);
    @(negedge CLK);
    READ = 0;
    WRITE = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit r;
    bit w;
    logic [7:0] a;
    for (int i = 0; i < 64; i++) rmem[i] = seed(i);
    model_reset();

    // Reset with a request held: nothing may be asserted.
    READ = 1;
    ADDRESS = 8'h25;
    #2;
    chk("rst busywait", 32'(BUSYWAIT), 32'h0);
    chk("rst mem_req", 32'({MEM_READ, MEM_WRITE}), 32'h0);
    chk("rst mem_addr", 32'(MEM_ADDRESS), 32'h0);
    chk("rst mem_wdata", MEM_WRITEDATA, 32'h0);
    chk("rst readdata", 32'(READDATA), 32'h0);
    chk_cnt("rst");
    @(negedge CLK);
    READ = 0;
    RESET = 1;

    do_acc(1, 0, 8'h25, 8'h00, 5, "cold_rd25");
    do_acc(1, 0, 8'h24, 8'h00, 5, "hit_rd24");
    do_acc(1, 0, 8'h27, 8'h00, 5, "hit_rd27");
    do_acc(0, 1, 8'h25, 8'h5A, 3, "hit_wr25");
    do_acc(1, 0, 8'h45, 8'h00, 2, "dirty_rd45");
    chk_cnt("scen123");
    do_acc(0, 1, 8'h80, 8'hC3, 4, "wrmiss80");
    do_acc(1, 0, 8'h80, 8'h00, 1, "rd80");
    do_acc(1, 0, 8'h00, 8'h00, 1, "evict80");
    do_acc(1, 1, 8'h46, 8'h77, 2, "rdwr46");

    for (int i = 0; i < 150; i++) begin
      a = {3'($urandom_range(0, 2)), 5'($urandom)};
      w = ($urandom_range(0, 2) == 0);
      r = !w || ($urandom_range(0, 4) == 0);
      do_acc(r, w, a, 8'($urandom), $urandom_range(1, 5), "rand");
    end
    chk_cnt("rand");

    // Reset during the third FETCH cycle of a cold-ish miss on index 1.
    do_acc(1, 0, 8'hE4, 8'h00, 1, "pre_rst");
    lat = 5;
    READ = 1;
    ADDRESS = 8'h25;
    #1;
    chk("abort detect busy", 32'(BUSYWAIT), 32'h1);
    for (int i = 0; i < 3; i++) @(negedge CLK);
    #1;
    chk("abort fetch3 mem_read", 32'(MEM_READ), 32'h1);
    RESET = 0;
    #1;
    chk("abort mem_read", 32'(MEM_READ), 32'h0);
    chk("abort busywait", 32'(BUSYWAIT), 32'h0);
    chk("abort mem_addr", 32'(MEM_ADDRESS), 32'h0);
    @(negedge CLK);
    READ = 0;
    RESET = 1;
    for (int i = 0; i < 64; i++) rmem[i] = wrt[i] ? mem[i] : seed(i);
    model_reset();
    chk_cnt("after_rst");
    do_acc(1, 0, 8'h25, 8'h00, 2, "remiss25");
    do_acc(1, 0, 8'hE4, 8'h00, 1, "remissE4");
    chk_cnt("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back, write-allocate data cache with its controller FSM, placed between the CPU's load/store path and the 8-bit data memory. It serves lwd/lwi/swd/swi byte accesses from a 32-byte on-chip store. On a miss it sequences block write-back and refill against the word-wide data memory, holding BUSYWAIT high so the CPU stalls its PC update until the access completes.

## Interface
- No parameters: geometry fixed at 8 lines × 4 bytes; tag 3 b = ADDRESS[7:5], index 3 b = ADDRESS[4:2], offset 2 b = ADDRESS[1:0].
- CLK  in  1  system clock, all state updates on posedge.
- RESET  in  1  asynchronous, active-low (0 = reset).
- READ  in  1  CPU load request, held until BUSYWAIT low.
- WRITE  in  1  CPU store request, held until BUSYWAIT low.
- ADDRESS  in  8  CPU byte address (ALU RESULT).
- WRITEDATA  in  8  store data (OPERAND1).
- READDATA  out  8  load data to register-file write mux.
- BUSYWAIT  out  1  stall to CPU.
- MEM_READ  out  1  block read request to data memory.
- MEM_WRITE  out  1  block write request to data memory.
- MEM_ADDRESS  out  6  block address {tag,index}.
- MEM_WRITEDATA  out  32  victim block, byte 0 in [7:0].
- MEM_READDATA  in  32  refill block, byte 0 in [7:0].
- MEM_BUSYWAIT  in  1  memory busy.
- HIT_COUNT  out  16  access hit counter (see Configuration).
- MISS_COUNT  out  16  access miss counter (see Configuration).

## Operation
- Per line: valid, dirty, tag[2:0], data[31:0].
- hit = valid[index] & (tag[index] == ADDRESS[7:5]).
- READ and WRITE both high: treated as WRITE.
- States: IDLE, WRITEBACK, FETCH, UPDATE.
- IDLE: no request → BUSYWAIT 0.
  - Read hit → READDATA = selected byte, combinational; BUSYWAIT 0.
  - Write hit → BUSYWAIT 0; byte written and dirty set at the next posedge.
  - Miss → BUSYWAIT 1 combinationally. Next state is WRITEBACK if valid & dirty, otherwise FETCH.
- WRITEBACK: MEM_WRITE 1; MEM_ADDRESS = {stored tag, index}; MEM_WRITEDATA = line data.
  - First cycle in the state: MEM_BUSYWAIT ignored.
  - Afterwards, exits to FETCH at the first posedge with MEM_BUSYWAIT 0.
- FETCH: MEM_READ 1; MEM_ADDRESS = {ADDRESS[7:5], index}; same exit rule.
  - On exit, MEM_READDATA is latched into a holding register; next state UPDATE.
- UPDATE: one cycle. Line data ← holding register, tag ← request tag, valid 1, dirty 0. Next state IDLE.
- Back in IDLE the request now hits; a write-allocate store completes as a write hit.
- BUSYWAIT is 1 in every non-IDLE state. MEM_READ and MEM_WRITE are never both 1.
- READDATA is 8'h00 when no read hit is present.

## Timing
- Reset (RESET=0, asynchronous): state IDLE; all valid/dirty cleared; BUSYWAIT, MEM_READ, MEM_WRITE 0; MEM_ADDRESS 0; MEM_WRITEDATA 0; READDATA 0; counters 0.
- Reset mid-miss aborts immediately. Memory request lines drop in the same instant; the line being refilled stays invalid.
- Hit latency: 0 stall cycles.
- Clean miss with memory busy for L cycles after request: BUSYWAIT high for L+3 cycles (IDLE detect, FETCH L+1, UPDATE).
- Dirty miss: adds L+1 cycles of WRITEBACK.
- CPU request changing while BUSYWAIT=1 is illegal; behaviour undefined.

## Configuration
- DCACHE_STATS_EN defined:
  - HIT_COUNT increments once per accepted access that hits in IDLE on first presentation.
  - MISS_COUNT increments once on each IDLE→WRITEBACK/FETCH transition.
  - The post-refill hit is not counted.
  - Both counters saturate at 16'hFFFF.
- DCACHE_STATS_EN undefined: counter logic is absent; HIT_COUNT and MISS_COUNT tied to 16'h0000.

## Test plan
- Cold read 0x25, memory L=5 returning 32'hDDCCBBAA:
  - FETCH with MEM_ADDRESS 6'h09;
  - BUSYWAIT high 8 cycles;
  - READDATA 8'hBB once BUSYWAIT falls.
- Read 0x24 then 0x27 after the fill → no stall; READDATA 8'hAA, then 8'hDD; no memory request.
- Write 8'h5A to 0x25 (hit, 0 stall), then read 0x45:
  - WRITEBACK at 6'h09 with MEM_WRITEDATA 32'hDDCC5AAA;
  - then FETCH at 6'h11;
  - line dirty clears.
- Write miss to clean line 0x80:
  - FETCH 6'h20, then UPDATE;
  - store lands in byte 0;
  - line dirty; no WRITEBACK issued.
- Assert RESET=0 in the 3rd FETCH cycle → MEM_READ and BUSYWAIT drop immediately. After release, read 0x25 misses again.
- With DCACHE_STATS_EN, run scenarios 1–3 → HIT_COUNT 3, MISS_COUNT 2. Without the macro → both remain 0.
